serial_word_deserializer: RTL and testbench
===========================================

# serial_word_deserializer

Serial-in, parallel-out receiver that sits directly downstream of the team's parallel-in/serial-out shift register. It collects an LSB-first bitstream, qualified by a bit-enable strobe and a start-of-frame marker, into WIDTH-bit words. Each completed word is presented on a one-deep output register with a valid/ready handshake. Words that cannot be delivered are dropped and flagged with a sticky overrun error.

## Interface
- WIDTH, 4, word length in bits; legal range 2..32.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low; deassertion is synchronous to i_clk in the surrounding design.
- i_sd  input  1  serial data bit; LSB of each word arrives first.
- i_sd_en  input  1  bit strobe; i_sd and i_sof are sampled only when this is 1.
- i_sof  input  1  start of frame; marks the sampled bit as bit 0 of a new word.
- i_ready  input  1  consumer accepts o_word when this and o_valid are both 1 at a rising edge.
- i_clr_err  input  1  synchronous clear of o_overrun.
- o_word  output  WIDTH  assembled word; bit 0 is the first received bit.
- o_valid  output  1  o_word holds an unconsumed word.
- o_busy  output  1  a frame is partially received (state SHIFT).
- o_overrun  output  1  sticky error: a completed word was dropped.

## Operation
- Internal state:
  - shift register sr[WIDTH-1:0]
  - bit counter cnt (clog2(WIDTH) bits)
  - FSM with states IDLE and SHIFT
  - output register plus its valid flag
- Every sampled bit shifts in at the MSB end: sr <= {i_sd, sr[WIDTH-1:1]}. After WIDTH shifts, the first bit sits at sr[0].
- IDLE:
  - i_sd_en=1 with i_sof=1: shift the bit in, set cnt=1, go to SHIFT.
  - i_sd_en=1 with i_sof=0: bit is ignored; state unchanged.
- SHIFT, when i_sd_en=1 and i_sof=0:
  - Shift the bit in and increment cnt.
  - If cnt==WIDTH-1 on entry, this bit completes the word. Go to IDLE and set cnt=0.
- Resync: i_sd_en=1 with i_sof=1 while in SHIFT discards the partial word. The bit is taken as bit 0 of a new word, cnt=1, state stays SHIFT. No error is raised.
- Word completion, with the final bit sampled at edge N:
  - If o_valid=0, or o_valid=1 and i_ready=1 at edge N: o_word <= completed word and o_valid=1 after edge N.
  - Otherwise (o_valid=1, i_ready=0): the completed word is discarded, o_word/o_valid are unchanged, and o_overrun is set to 1.
- Handshake:
  - o_valid && i_ready at an edge consumes the word. o_valid goes to 0 after that edge unless a new word loads at the same edge.
  - o_word is held stable while o_valid=1 and i_ready=0.
  - i_ready has no effect when o_valid=0.
- o_overrun:
  - Set on a dropped word; cleared by i_clr_err.
  - If set and clear coincide at the same edge, set wins.
- o_busy = (state == SHIFT).

## Timing
- Reset (i_rst_n=0, asynchronous) forces: state=IDLE, cnt=0, sr=0, o_word=0, o_valid=0, o_busy=0, o_overrun=0.
- Reset mid-frame or with a word pending loses all data. No word is emitted after reset deasserts until a new i_sof is sampled.
- Latency: o_valid rises in the cycle following the rising edge that samples the last bit, i.e. 1 clock after the final strobe.
- Back-to-back frames are supported:
  - The i_sof bit of the next frame may arrive on the clock immediately after the final bit.
  - With i_ready held at 1, sustained full-rate input loses no words.
- Gaps are allowed: i_sd_en may be 0 for any number of cycles mid-frame. State and cnt hold during gaps.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Basic word: reset, i_ready=1, strobe bits 0,1,0,1 with i_sof on the first -> o_word=4'b1010 and o_valid=1 for exactly one cycle, starting 1 clock after the 4th strobe; o_busy high from after the 1st strobe through the 4th.
- Back-pressure and overrun: i_ready=0; send 4'b1100, then 4'b0011 -> o_word stays 4'b1100 and o_overrun=1. Then i_ready=1 -> 4'b1100 is consumed and o_valid=0. Then i_clr_err -> o_overrun=0.
- Load at consume: o_valid=1 holding 4'hA, with i_ready=1 at the same edge a second word 4'h5 completes -> o_word=4'h5, o_valid stays 1, o_overrun stays 0.
- Resync and ignore: in IDLE, 3 strobes without i_sof are ignored (o_busy=0). Then send 2 bits, re-assert i_sof, and send 1,1,1,1 -> exactly one word, 4'hF.
- Async reset mid-frame: after 2 bits, pulse i_rst_n low between clock edges -> all outputs 0 immediately. The remaining 2 bits without i_sof produce no word.
- Gapped strobes and WIDTH=8: i_sd_en asserted every 3rd cycle for 8 bits of 8'hA5, LSB first -> o_word=8'hA5, o_valid=1 one clock after the 8th strobe.

Source files
------------

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: LSB-first serial-to-parallel receiver with valid/ready output and sticky overrun
module serial_word_deserializer #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_sd,
   input  logic             i_sd_en,
   input  logic             i_sof,
   input  logic             i_ready,
   input  logic             i_clr_err,
   output logic [WIDTH-1:0] o_word,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_overrun
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_nxt;
   logic [CW-1:0]    cnt;
   logic             done;
   logic             load;

   assign sr_nxt = {i_sd, sr[WIDTH-1:1]};
   assign done   = i_sd_en && !i_sof && state == SHIFT && cnt == CW'(WIDTH - 1);
   assign load   = done && (!o_valid || i_ready);
   assign o_busy = state == SHIFT;

   // frame assembly: sof always restarts a word, plain bits only count inside a frame
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else if (i_sd_en && i_sof) begin
         state <= SHIFT;
         sr    <= sr_nxt;
         cnt   <= CW'(1);
      end else if (i_sd_en && state == SHIFT) begin
         state <= done ? IDLE : SHIFT;
         sr    <= sr_nxt;
         cnt   <= done ? '0 : cnt + CW'(1);
      end
   end

   // one-deep output slot; a completed word that finds the slot occupied and not draining is dropped
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_word    <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         if (load) o_word <= sr_nxt;
         o_valid   <= load || (o_valid && !i_ready);
         o_overrun <= (done && o_valid && !i_ready) || (o_overrun && !i_clr_err);
      end
   end
endmodule

// File: tb/tb_serial_word_deserializer.sv
// tb_serial_word_deserializer: directed scenario checks for the serial word deserializer
module tb_serial_word_deserializer;
   logic clk = 1'b0;
   logic rst_n, sd, en, sof, ready, clr;
   logic [3:0] w4;
   logic [7:0] w8;
   logic v4, b4, o4, v8, b8, o8;
   int total = 0;
   int bad = 0;

   serial_word_deserializer #(.WIDTH(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_sd(sd), .i_sd_en(en), .i_sof(sof),
      .i_ready(ready), .i_clr_err(clr),
      .o_word(w4), .o_valid(v4), .o_busy(b4), .o_overrun(o4)
   );

   serial_word_deserializer #(.WIDTH(8)) dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_sd(sd), .i_sd_en(en), .i_sof(sof),
      .i_ready(ready), .i_clr_err(clr),
      .o_word(w8), .o_valid(v8), .o_busy(b8), .o_overrun(o8)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic d, input logic e, input logic s);
      sd = d; en = e; sof = s;
      tick();
   endtask

   task automatic send_word(input logic [3:0] w);
      for (int i = 0; i < 4; i++) drive(w[i], 1'b1, i == 0);
      en = 1'b0; sof = 1'b0; sd = 1'b0;
   endtask

   task automatic test_reset();
      tick(); tick();
      total++; if (w4 !== 4'h0) begin bad++; $display("FAIL reset_word got=%h exp=0", w4); end
      total++; if (v4 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", v4); end
      total++; if (b4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", b4); end
      total++; if (o4 !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", o4); end
      total++; if (v8 !== 1'b0 || w8 !== 8'h00) begin bad++; $display("FAIL reset_w8 got=%b/%h exp=0/00", v8, w8); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      ready = 1'b1;
      drive(1'b0, 1'b1, 1'b1);
      total++; if (b4 !== 1'b1 || v4 !== 1'b0) begin bad++; $display("FAIL basic_b1 busy/valid got=%b/%b exp=1/0", b4, v4); end
      drive(1'b1, 1'b1, 1'b0);
      total++; if (b4 !== 1'b1 || v4 !== 1'b0) begin bad++; $display("FAIL basic_b2 busy/valid got=%b/%b exp=1/0", b4, v4); end
      drive(1'b0, 1'b1, 1'b0);
      total++; if (b4 !== 1'b1 || v4 !== 1'b0) begin bad++; $display("FAIL basic_b3 busy/valid got=%b/%b exp=1/0", b4, v4); end
      drive(1'b1, 1'b1, 1'b0);
      total++; if (v4 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", v4); end
      total++; if (w4 !== 4'b1010) begin bad++; $display("FAIL basic_word got=%b exp=1010", w4); end
      total++; if (b4 !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", b4); end
      drive(1'b0, 1'b0, 1'b0);
      total++; if (v4 !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%b exp=0", v4); end
   endtask

   task automatic test_backpressure();
      ready = 1'b0;
      send_word(4'b1100);
      total++; if (v4 !== 1'b1 || w4 !== 4'b1100) begin bad++; $display("FAIL bp_first got=%b/%b exp=1/1100", v4, w4); end
      send_word(4'b0011);
      total++; if (w4 !== 4'b1100) begin bad++; $display("FAIL bp_hold got=%b exp=1100", w4); end
      total++; if (o4 !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b exp=1", o4); end
      ready = 1'b1;
      tick();
      total++; if (v4 !== 1'b0) begin bad++; $display("FAIL bp_consume got=%b exp=0", v4); end
      total++; if (o4 !== 1'b1) begin bad++; $display("FAIL bp_sticky got=%b exp=1", o4); end
      ready = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      total++; if (o4 !== 1'b0) begin bad++; $display("FAIL bp_clear got=%b exp=0", o4); end
   endtask

   task automatic test_set_wins();
      ready = 1'b0; clr = 1'b1;
      send_word(4'h1);
      send_word(4'h2);
      total++; if (o4 !== 1'b1) begin bad++; $display("FAIL setwins_overrun got=%b exp=1", o4); end
      total++; if (w4 !== 4'h1) begin bad++; $display("FAIL setwins_word got=%h exp=1", w4); end
      tick();
      clr = 1'b0;
      total++; if (o4 !== 1'b0) begin bad++; $display("FAIL setwins_clear got=%b exp=0", o4); end
      ready = 1'b1;
      tick();
      total++; if (v4 !== 1'b0) begin bad++; $display("FAIL setwins_drain got=%b exp=0", v4); end
   endtask

   task automatic test_load_at_consume();
      ready = 1'b0;
      send_word(4'hA);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      total++; if (v4 !== 1'b1 || w4 !== 4'hA) begin bad++; $display("FAIL lac_hold got=%b/%h exp=1/a", v4, w4); end
      ready = 1'b1;
      drive(1'b0, 1'b1, 1'b0);
      en = 1'b0;
      total++; if (w4 !== 4'h5) begin bad++; $display("FAIL lac_word got=%h exp=5", w4); end
      total++; if (v4 !== 1'b1) begin bad++; $display("FAIL lac_valid got=%b exp=1", v4); end
      total++; if (o4 !== 1'b0) begin bad++; $display("FAIL lac_overrun got=%b exp=0", o4); end
      tick();
      total++; if (v4 !== 1'b0) begin bad++; $display("FAIL lac_drain got=%b exp=0", v4); end
   endtask

   task automatic test_resync();
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         total++; if (b4 !== 1'b0 || v4 !== 1'b0) begin bad++; $display("FAIL resync_ignore%0d busy/valid got=%b/%b exp=0/0", i, b4, v4); end
      end
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      total++; if (v4 !== 1'b0 || b4 !== 1'b1) begin bad++; $display("FAIL resync_partial valid/busy got=%b/%b exp=0/1", v4, b4); end
      drive(1'b1, 1'b1, 1'b0);
      en = 1'b0;
      total++; if (v4 !== 1'b1 || w4 !== 4'hF) begin bad++; $display("FAIL resync_word got=%b/%h exp=1/f", v4, w4); end
      tick();
      total++; if (v4 !== 1'b0) begin bad++; $display("FAIL resync_single got=%b exp=0", v4); end
   endtask

   task automatic test_async_reset();
      ready = 1'b0;
      send_word(4'h6);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      en = 1'b0;
      total++; if (b4 !== 1'b1 || v4 !== 1'b1) begin bad++; $display("FAIL areset_pre busy/valid got=%b/%b exp=1/1", b4, v4); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (w4 !== 4'h0 || v4 !== 1'b0 || b4 !== 1'b0 || o4 !== 1'b0) begin bad++; $display("FAIL areset_now word/valid/busy/ovr got=%h/%b/%b/%b exp=0/0/0/0", w4, v4, b4, o4); end
      #1 rst_n = 1'b1;
      ready = 1'b1;
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      en = 1'b0;
      tick();
      total++; if (v4 !== 1'b0 || b4 !== 1'b0) begin bad++; $display("FAIL areset_noword valid/busy got=%b/%b exp=0/0", v4, b4); end
   endtask

   task automatic test_back_to_back();
      ready = 1'b1;
      send_word(4'h3);
      total++; if (v4 !== 1'b1 || w4 !== 4'h3) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/3", v4, w4); end
      drive(1'b0, 1'b1, 1'b1);
      total++; if (v4 !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", v4); end
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      send_word(4'h9);
      total++; if (v4 !== 1'b1 || w4 !== 4'h9) begin bad++; $display("FAIL b2b_third got=%b/%h exp=1/9", v4, w4); end
      total++; if (o4 !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", o4); end
      tick();
   endtask

   task automatic test_gapped_w8();
      logic [7:0] pat;
      pat = 8'hA5;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(pat[i], 1'b1, i == 0);
         if (i == 7) begin
            total++; if (v8 !== 1'b1 || w8 !== 8'hA5) begin bad++; $display("FAIL gap8_word got=%b/%h exp=1/a5", v8, w8); end
         end else begin
            total++; if (v8 !== 1'b0 || b8 !== 1'b1) begin bad++; $display("FAIL gap8_bit%0d valid/busy got=%b/%b exp=0/1", i, v8, b8); end
         end
         drive(1'b0, 1'b0, 1'b0);
         drive(1'b0, 1'b0, 1'b0);
      end
      total++; if (v8 !== 1'b0 || b8 !== 1'b0) begin bad++; $display("FAIL gap8_drain valid/busy got=%b/%b exp=0/0", v8, b8); end
   endtask

   initial begin
      rst_n = 1'b0; sd = 1'b0; en = 1'b0; sof = 1'b0; ready = 1'b0; clr = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_set_wins();
      test_load_at_consume();
      test_resync();
      test_async_reset();
      test_back_to_back();
      test_gapped_w8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
